// File: rtl/beat_window_fifo_pkg.sv
// Shared constants and helpers for the heart-rate sliding-window sample FIFO.
package beat_window_fifo_pkg;

    localparam int unsigned SAMPLE_WIDTH  = 1;
    localparam int unsigned DEFAULT_DEPTH = 256;

    // Wrapped pointer increment by explicit compare, so DEPTH need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/beat_window_fifo_if.sv
// Sample/status bundle between the beat detector, the window FIFO and the rate counter.
interface beat_window_fifo_if
    import beat_window_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d;
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic [AW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output d, wen, ren,
        input  q, full, empty, count, overflow, underflow
    );

    modport slave (
        input  d, wen, ren,
        output q, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/beat_window_fifo_mem.sv
// DEPTH x WIDTH sample store: one synchronous write port, one asynchronous read port.
module beat_window_fifo_mem #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the top masks q while empty, so stale contents never escape.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/beat_window_fifo.sv
// Sliding-window delay FIFO: first-word-fall-through, early full, sticky overflow/underflow.
module beat_window_fifo
    import beat_window_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned FULL_LEVEL = DEPTH - 1
) (
    input  logic              clock,
    input  logic              reset,
    beat_window_fifo_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [AW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;

    // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        // A write into a full window is legal when the oldest sample leaves on the same edge.
        if (bus.wen && (count < AW'(DEPTH) || bus.ren)) wr_ok = 1'b1;
        if (bus.ren && count != '0)                     rd_ok = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (rd_ok) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + AW'(1);
                2'b01:   count <= count - AW'(1);
                default: count <= count;
            endcase
            overflow  <= overflow  | (bus.wen & ~wr_ok);
            underflow <= underflow | (bus.ren & ~rd_ok);
        end
    end

    beat_window_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clock (clock),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.d),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign bus.q         = (count == '0) ? '0 : rd_data;
    assign bus.full      = (count >= AW'(FULL_LEVEL));
    assign bus.empty     = (count == '0);
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;

endmodule

// File: tb/tb_beat_window_fifo.sv
// Randomized bench for beat_window_fifo (DEPTH=8) against a queue-based reference model.
module tb_beat_window_fifo;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned FULL_LEVEL = 7;

    logic clock;
    logic reset;

    beat_window_fifo_if #(.WIDTH(1), .DEPTH(DEPTH)) bus ();

    beat_window_fifo #(
        .WIDTH      (1),
        .DEPTH      (DEPTH),
        .FULL_LEVEL (FULL_LEVEL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit model_q[$];
    bit wr_hist[$];
    bit exp_ovf;
    bit exp_unf;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic check_all();
        check("count",     32'(bus.count),     model_q.size());
        check("q",         32'(bus.q),         (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
        check("full",      32'(bus.full),      32'(model_q.size() >= FULL_LEVEL));
        check("empty",     32'(bus.empty),     32'(model_q.size() == 0));
        check("overflow",  32'(bus.overflow),  32'(exp_ovf));
        check("underflow", 32'(bus.underflow), 32'(exp_unf));
    endtask

    // Drive one cycle, let the reference model take the same edge, then compare everything.
    task automatic cycle(input bit rst, input bit d, input bit wen, input bit ren);
        int unsigned n;
        bit          w_ok;
        bit          r_ok;
        reset   = rst;
        bus.d   = d;
        bus.wen = wen;
        bus.ren = ren;
        @(posedge clock);
        n = model_q.size();
        if (rst) begin
            model_q.delete();
            wr_hist.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            w_ok = wen && (n < DEPTH || ren);
            r_ok = ren && n > 0;
            if (wen && !w_ok) exp_ovf = 1'b1;
            if (ren && !r_ok) exp_unf = 1'b1;
            if (r_ok) void'(model_q.pop_front());
            if (w_ok) begin
                model_q.push_back(d);
                wr_hist.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bit pattern [7];
        bit first_d;
        pattern = '{1, 0, 1, 1, 0, 0, 1};
        reset   = 1'b1;
        bus.d   = 1'b0;
        bus.wen = 1'b0;
        bus.ren = 1'b0;

        // Reset then idle.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_q",     32'(bus.q),     32'd0);

        // Fill to FULL_LEVEL with the fixed pattern.
        for (int i = 0; i < 7; i++) cycle(0, pattern[i], 1, 0);
        check("fill7_count", 32'(bus.count), 32'd7);
        check("fill7_full",  32'(bus.full),  32'd1);
        check("fill7_q",     32'(bus.q),     32'd1);
        cycle(0, 1, 1, 0);
        check("fill8_count", 32'(bus.count), 32'd8);

        // Steady window: read+write each cycle, q lags the writes by exactly DEPTH.
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 1, 1);
            check("steady_count", 32'(bus.count), 32'd8);
            check("steady_lag8",  32'(bus.q),     32'(wr_hist[wr_hist.size() - DEPTH]));
        end

        // Overflow: writes into a full window are dropped.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd8);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);

        // Underflow from empty, then a same-cycle write while empty (no bypass).
        cycle(0, 0, 0, 1);
        check("unf_flag",  32'(bus.underflow), 32'd1);
        check("unf_count", 32'(bus.count),     32'd0);
        cycle(0, 1, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("unf_cleared", 32'(bus.underflow), 32'd0);
        check("ovf_cleared", 32'(bus.overflow),  32'd0);

        // Random mixed traffic.
        for (int i = 0; i < 60; i++)
            cycle(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));

        // Reset in the middle of a stream.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1'($urandom_range(0, 1)), 1, 0);
        cycle(1, 1, 1, 0);
        first_d = 1'($urandom_range(0, 1));
        cycle(0, first_d, 1, 0);
        cycle(0, 1'($urandom_range(0, 1)), 1, 0);
        cycle(0, 1'($urandom_range(0, 1)), 1, 0);
        check("mid_rst_count", 32'(bus.count), 32'd3);
        check("mid_rst_q",     32'(bus.q),     32'(first_d));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time budget");
        $fatal(1);
    end

endmodule
